bidi_count_bank: RTL

//  Bank of DEPTH counter registers sharing one tristate data bus.

---
 rtl/bidi_pkg.sv | 23 ++
 rtl/bidi_count_cell.sv | 75 +++++++
 rtl/bidi_count_bank.sv | 93 +++++++++
 3 files changed

// File: rtl/bidi_pkg.sv
// Shared constants and helpers for the bidirectional counter bank.
//   RW_READ / RW_WRITE : bus direction encodings for the RW pin
//   DEF_WIDTH / DEF_DEPTH : default register width and register count
//   clog2()            : ceiling log2, used to size the address bus
package bidi_pkg;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 4;

    // Smallest n with 2**n >= value (value >= 2 in every use here).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bidi_count_cell.sv
// One counter register of the bank with its step/wrap/saturate logic and
// sticky overflow bit.
// Ports:
//   clk, srst    : clock, synchronous active-high reset
//   wr_en        : load wr_data this edge (already address-qualified)
//   cnt_en       : count this edge (already address-qualified, write-masked)
//   down         : 1 = count down, 0 = count up
//   sat_mode     : 1 = saturate at 0 / all-ones, 0 = wrap
//   wr_data      : data to load
//   value        : current register contents
//   ovf          : sticky overflow/underflow flag
//   wrap_event   : combinational, this edge's count over/underflows
module bidi_count_cell #(
    parameter int          WIDTH = 16,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             wr_en,
    input  logic             cnt_en,
    input  logic             down,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] value,
    output logic             ovf,
    output logic             wrap_event
);

    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

    logic [WIDTH-1:0] value_reg, value_next;
    logic             ovf_reg, ovf_next;
    logic [WIDTH:0]   sum_up;
    logic [WIDTH-1:0] diff_down;
    logic             overflow, underflow;

    always_comb begin
        // One extra bit on the up path exposes the carry out directly.
        sum_up     = {1'b0, value_reg} + {1'b0, STEP_V};
        diff_down  = value_reg - STEP_V;
        overflow   = sum_up[WIDTH];
        underflow  = (value_reg < STEP_V);
        wrap_event = cnt_en && (down ? underflow : overflow);

        value_next = value_reg;
        ovf_next   = ovf_reg;
        if (wr_en) begin
            value_next = wr_data;
            ovf_next   = 1'b0;
        end else if (cnt_en) begin
            if (wrap_event && sat_mode) begin
                value_next = down ? '0 : '1;
            end else begin
                value_next = down ? diff_down : sum_up[WIDTH-1:0];
            end
            if (wrap_event) begin
                ovf_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            value_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            value_reg <= value_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign value = value_reg;
    assign ovf   = ovf_reg;

endmodule

// File: rtl/bidi_count_bank.sv
// Bank of DEPTH counter registers on one shared tristate data bus.
// Each register can be written, read back, incremented or decremented;
// counting wraps or saturates and each register keeps a sticky overflow flag.
// Ports:
//   CLOCK, RESET : clock, synchronous active-high reset
//   ENABLE, RW   : bus access enable; RW=1 read (bank drives DATA), RW=0 write
//   ADDR         : register select for both bus access and counting
//   COUNT, DOWN  : count the selected register, direction
//   SAT_MODE     : 1 = saturate, 0 = wrap
//   DATA         : bidirectional data bus
//   CARRY        : registered one-cycle pulse on count over/underflow
//   OVF          : sticky per-register overflow flags
module bidi_count_bank
    import bidi_pkg::*;
#(
    parameter int          WIDTH  = DEF_WIDTH,
    parameter int          DEPTH  = DEF_DEPTH,
    parameter int          ADDR_W = clog2(DEPTH),
    parameter int unsigned STEP   = 1
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic              RW,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic              COUNT,
    input  logic              DOWN,
    input  logic              SAT_MODE,
    inout  wire  [WIDTH-1:0]  DATA,
    output logic              CARRY,
    output logic [DEPTH-1:0]  OVF
);

    logic [DEPTH-1:0] sel;
    logic [DEPTH-1:0] wrap_events;
    logic [WIDTH-1:0] values [DEPTH];
    logic [WIDTH-1:0] read_data;
    logic             bus_write;
    logic             bus_read;
    logic             carry_reg;

    assign bus_write = ENABLE && (RW == RW_WRITE);
    assign bus_read  = ENABLE && (RW == RW_READ);

    // Out-of-range addresses match no cell, so they read as 0 and
    // writes/counts to them fall on the floor.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_cell
            assign sel[gi] = (ADDR == ADDR_W'(gi));

            bidi_count_cell #(
                .WIDTH (WIDTH),
                .STEP  (STEP)
            ) u_cell (
                .clk        (CLOCK),
                .srst       (RESET),
                .wr_en      (bus_write && sel[gi]),
                // A write in the same cycle always wins over a count.
                .cnt_en     (COUNT && !bus_write && sel[gi]),
                .down       (DOWN),
                .sat_mode   (SAT_MODE),
                .wr_data    (DATA),
                .value      (values[gi]),
                .ovf        (OVF[gi]),
                .wrap_event (wrap_events[gi])
            );
        end
    endgenerate

    // Select is one-hot (or empty), so an OR of gated values is the mux.
    always_comb begin
        read_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) begin
                read_data = read_data | values[i];
            end
        end
    end

    assign DATA = bus_read ? read_data : {WIDTH{1'bz}};

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            carry_reg <= 1'b0;
        end else begin
            carry_reg <= |wrap_events;
        end
    end

    assign CARRY = carry_reg;

endmodule
